// File: rtl/cp0_regfile_v2.sv
// MIPS32 coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, PRId, Config.
// Latency: MTC0/exception/ERET updates land on the next clk edge; data_o is a combinational read.
// Backpressure: none, every write and commit event is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   we_i/waddr_i/wdata_i MTC0 write port; raddr_i/data_o MFC0 read port
//   int_i               hardware interrupt levels, sampled into Cause.IP every cycle
//   excp_valid_i, excp_code_i, eret_i, pc_i, is_in_delayslot_i, badvaddr_i  commit-stage events
//   status_o, cause_o, epc_o, timer_int_o, int_req_o  state exported to the exception unit
module cp0_regfile_v2 #(
   parameter int          HW_INT_NUM   = 6,
   parameter int          TIMER_IP     = 7,
   parameter int          COUNT_DIV    = 2,
   parameter logic [31:0] PRID_VALUE   = 32'h0001_8000,
   parameter logic [31:0] CONFIG_VALUE = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [4:0]            waddr_i,
   input  logic [31:0]           wdata_i,
   input  logic [4:0]            raddr_i,
   output logic [31:0]           data_o,
   input  logic [HW_INT_NUM-1:0] int_i,
   input  logic                  excp_valid_i,
   input  logic [4:0]            excp_code_i,
   input  logic                  eret_i,
   input  logic [31:0]           pc_i,
   input  logic                  is_in_delayslot_i,
   input  logic [31:0]           badvaddr_i,
   output logic [31:0]           status_o,
   output logic [31:0]           cause_o,
   output logic [31:0]           epc_o,
   output logic                  timer_int_o,
   output logic                  int_req_o
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;
   localparam logic [4:0] REG_CONFIG   = 5'd16;

   localparam logic [31:0] STATUS_RESET = 32'h1040_0000;
   // Only IM[15:8], EXL[1] and IE[0] are software writable.
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

   localparam int            PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);
   localparam logic [2:0]    TI_BIT     = 3'(TIMER_IP);

   logic [31:0]   count_q, compare_q, status_q, cause_q, epc_q, badvaddr_q;
   logic [PW-1:0] presc_q;
   logic          int_req_q;

   logic [31:0]   count_n, compare_n, status_n, cause_n, epc_n, badvaddr_n;
   logic [PW-1:0] presc_n;
   logic          int_req_n;

   logic          wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_badvaddr;
   logic          tick, ti_set;
   logic          bd_n, ti_n;
   logic [1:0]    sw_n;
   logic [4:0]    code_n;
   logic [5:0]    hw_n;
   logic [7:0]    ip_n;

   assign wr_count    = we_i && (waddr_i == REG_COUNT);
   assign wr_compare  = we_i && (waddr_i == REG_COMPARE);
   assign wr_status   = we_i && (waddr_i == REG_STATUS);
   assign wr_cause    = we_i && (waddr_i == REG_CAUSE);
   assign wr_epc      = we_i && (waddr_i == REG_EPC);
   assign wr_badvaddr = we_i && (waddr_i == REG_BADVADDR);

   assign tick = (presc_q == PRESC_LAST);

   always_comb begin
      count_n    = count_q;
      compare_n  = compare_q;
      status_n   = status_q;
      epc_n      = epc_q;
      badvaddr_n = badvaddr_q;
      presc_n    = presc_q;
      bd_n       = cause_q[31];
      ti_n       = cause_q[30];
      sw_n       = cause_q[9:8];
      code_n     = cause_q[6:2];
      hw_n       = '0;
      hw_n[HW_INT_NUM-1:0] = int_i;
      ti_set     = 1'b0;

      // Count: an MTC0 to Count overrides the prescaler-driven increment.
      if (wr_count) begin
         count_n = wdata_i;
         presc_n = '0;
      end else if (tick) begin
         count_n = count_q + 32'd1;
         presc_n = '0;
         ti_set  = (count_q + 32'd1 == compare_q);
      end else begin
         presc_n = presc_q + PW'(1);
      end

      // Compare write clears TI and beats a same-cycle match.
      if (wr_compare) begin
         compare_n = wdata_i;
         ti_n      = 1'b0;
      end else if (ti_set) begin
         ti_n = 1'b1;
      end

      // MTC0 first; commit events below overwrite the fields they own.
      if (wr_status)   status_n   = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
      if (wr_cause)    sw_n       = wdata_i[9:8];
      if (wr_epc)      epc_n      = wdata_i;
      if (wr_badvaddr) badvaddr_n = wdata_i;

      if (excp_valid_i) begin
         code_n = excp_code_i;
         // Nested exceptions keep the EPC/BD of the outermost one.
         if (!status_q[1]) begin
            epc_n = is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
            bd_n  = is_in_delayslot_i;
         end
         status_n[1] = 1'b1;
         // TLB refill/invalid/modified and address-error codes carry a faulting address.
         if (excp_code_i >= 5'd1 && excp_code_i <= 5'd5) badvaddr_n = badvaddr_i;
      end else if (eret_i) begin
         status_n[1] = 1'b0;
      end

      ip_n         = {hw_n, sw_n};
      ip_n[TI_BIT] = ip_n[TI_BIT] | ti_n;

      cause_n        = '0;
      cause_n[31]    = bd_n;
      cause_n[30]    = ti_n;
      cause_n[15:8]  = ip_n;
      cause_n[6:2]   = code_n;

      // Evaluated on the state being written this edge; suppressed right after an exception.
      int_req_n = !excp_valid_i && status_n[0] && !status_n[1] && (|(ip_n & status_n[15:8]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         compare_q  <= '0;
         status_q   <= STATUS_RESET;
         cause_q    <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
         presc_q    <= '0;
         int_req_q  <= 1'b0;
      end else begin
         count_q    <= count_n;
         compare_q  <= compare_n;
         status_q   <= status_n;
         cause_q    <= cause_n;
         epc_q      <= epc_n;
         badvaddr_q <= badvaddr_n;
         presc_q    <= presc_n;
         int_req_q  <= int_req_n;
      end
   end

   always_comb begin
      data_o = '0;
      case (raddr_i)
         REG_BADVADDR: data_o = badvaddr_q;
         REG_COUNT:    data_o = count_q;
         REG_COMPARE:  data_o = compare_q;
         REG_STATUS:   data_o = status_q;
         REG_CAUSE:    data_o = cause_q;
         REG_EPC:      data_o = epc_q;
         REG_PRID:     data_o = PRID_VALUE;
         REG_CONFIG:   data_o = CONFIG_VALUE;
         default:      data_o = '0;
      endcase
   end

   assign status_o    = status_q;
   assign cause_o     = cause_q;
   assign epc_o       = epc_q;
   assign timer_int_o = cause_q[30];
   assign int_req_o   = int_req_q;

endmodule

// File: tb/tb_cp0_regfile_v2.sv
// Directed bench for cp0_regfile_v2 with default parameters (HW_INT_NUM=6, TIMER_IP=7, COUNT_DIV=2).
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
// Table-driven commit/MTC0 vectors plus hand-written timer and asynchronous-reset sequences.
module tb_cp0_regfile_v2;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i;
   logic [4:0]  raddr_i;
   logic [31:0] data_o;
   logic [5:0]  int_i;
   logic        excp_valid_i;
   logic [4:0]  excp_code_i;
   logic        eret_i;
   logic [31:0] pc_i;
   logic        is_in_delayslot_i;
   logic [31:0] badvaddr_i;
   logic [31:0] status_o, cause_o, epc_o;
   logic        timer_int_o, int_req_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   cp0_regfile_v2 dut (
      .clk(clk), .rst(rst),
      .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
      .raddr_i(raddr_i), .data_o(data_o),
      .int_i(int_i),
      .excp_valid_i(excp_valid_i), .excp_code_i(excp_code_i), .eret_i(eret_i),
      .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i), .badvaddr_i(badvaddr_i),
      .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
      .timer_int_o(timer_int_o), .int_req_o(int_req_o)
   );

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [5:0]  intv;
      logic        excp;
      logic [4:0]  code;
      logic        eret;
      logic [31:0] pc;
      logic        ds;
      logic [31:0] bad;
      logic [4:0]  raddr;
      logic [31:0] exp_data;
      logic [31:0] exp_status;
      logic [31:0] exp_cause;
      int          exp_ireq;   // -1: not checked on this vector
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive one cycle of stimulus on the falling edge, then wait past the next rising edge.
   task automatic apply(input vec_t v);
      @(negedge clk);
      we_i = v.we; waddr_i = v.waddr; wdata_i = v.wdata; int_i = v.intv;
      excp_valid_i = v.excp; excp_code_i = v.code; eret_i = v.eret;
      pc_i = v.pc; is_in_delayslot_i = v.ds; badvaddr_i = v.bad; raddr_i = v.raddr;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic [5:0] intv, input logic excp, input logic [4:0] code,
                               input logic eret, input logic [31:0] pc, input logic ds,
                               input logic [31:0] bad, input logic [4:0] raddr,
                               input logic [31:0] exp_data, input logic [31:0] exp_status,
                               input logic [31:0] exp_cause, input int exp_ireq);
      vec_t v;
      v.we = we; v.waddr = waddr; v.wdata = wdata; v.intv = intv; v.excp = excp;
      v.code = code; v.eret = eret; v.pc = pc; v.ds = ds; v.bad = bad; v.raddr = raddr;
      v.exp_data = exp_data; v.exp_status = exp_status; v.exp_cause = exp_cause;
      v.exp_ireq = exp_ireq;
      return v;
   endfunction

   function automatic vec_t wr(input logic [4:0] a, input logic [31:0] d, input logic [4:0] ra);
      return mk(1'b1, a, d, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, ra, 32'd0, 32'd0, 32'd0, -1);
   endfunction

   function automatic vec_t rd(input logic [4:0] ra);
      return mk(1'b0, 5'd0, 32'd0, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, ra, 32'd0, 32'd0, 32'd0, -1);
   endfunction

   initial begin
      vec_t v;

      rst = 1'b1;
      we_i = 1'b0; waddr_i = '0; wdata_i = '0; int_i = '0;
      excp_valid_i = 1'b0; excp_code_i = '0; eret_i = 1'b0;
      pc_i = '0; is_in_delayslot_i = 1'b0; badvaddr_i = '0; raddr_i = 5'd9;

      // ---- Reset state ----
      #1;
      check("rst_count", data_o, 32'd0);
      check("rst_status", status_o, 32'h1040_0000);
      check("rst_cause", cause_o, 32'd0);
      check("rst_epc", epc_o, 32'd0);
      check("rst_int_req", {31'd0, int_req_o}, 32'd0);
      check("rst_timer_int", {31'd0, timer_int_o}, 32'd0);
      raddr_i = 5'd8; #1;
      check("rst_badvaddr", data_o, 32'd0);
      raddr_i = 5'd9;

      // ---- Free-running count: 10 edges at COUNT_DIV=2 give Count=5 ----
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("count_after_10", data_o, 32'd5);
      check("status_after_10", status_o, 32'h1040_0000);
      check("int_req_after_10", {31'd0, int_req_o}, 32'd0);

      // ---- Timer: restart Count at 0, Compare=8, Status IM7|IE ----
      apply(wr(5'd9, 32'd0, 5'd9));                    // prescaler cleared, Count=0
      apply(wr(5'd11, 32'd8, 5'd11));
      check("compare_rd", data_o, 32'd8);
      apply(wr(5'd12, 32'h0000_8001, 5'd12));
      check("status_im7_ie", data_o, 32'h1040_8001);
      for (int i = 0; i < 13; i++) apply(rd(5'd9));
      check("count_pre_match", data_o, 32'd7);
      check("ti_pre_match", {31'd0, timer_int_o}, 32'd0);
      check("ireq_pre_match", {31'd0, int_req_o}, 32'd0);
      apply(rd(5'd9));
      check("count_match", data_o, 32'd8);
      check("ti_set", {31'd0, timer_int_o}, 32'd1);
      check("cause_ti_ip7", {30'd0, cause_o[30], cause_o[15]}, 32'd3);
      apply(rd(5'd9));
      check("ireq_timer", {31'd0, int_req_o}, 32'd1);
      check("ti_sticky", {31'd0, timer_int_o}, 32'd1);
      apply(wr(5'd11, 32'd20, 5'd13));
      check("ti_clear", {31'd0, timer_int_o}, 32'd0);
      check("cause_ti_clear", {30'd0, cause_o[30], cause_o[15]}, 32'd0);
      apply(rd(5'd9));
      check("ireq_timer_clear", {31'd0, int_req_o}, 32'd0);
      apply(wr(5'd11, 32'hFFFF_0000, 5'd11));          // park the timer far away

      // ---- Exceptions, ERET, masked writes: table ----
      //            we  waddr  wdata          int   excp code   eret pc             ds    bad            raddr  data           status         cause          ireq
      vecs[0]  = mk(0, 5'd0,  32'd0,         6'd0, 1,   5'd4,  0,   32'h8000_0104, 1'b1, 32'hDEAD_BEE1, 5'd14, 32'h8000_0100, 32'h1040_8003, 32'h8000_0010, 0);
      vecs[1]  = mk(0, 5'd0,  32'd0,         6'd0, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd8,  32'hDEAD_BEE1, 32'h1040_8003, 32'h8000_0010, 0);
      vecs[2]  = mk(0, 5'd0,  32'd0,         6'd0, 1,   5'd8,  0,   32'h8000_0200, 1'b0, 32'h1234_5678, 5'd14, 32'h8000_0100, 32'h1040_8003, 32'h8000_0020, 0);
      vecs[3]  = mk(0, 5'd0,  32'd0,         6'd0, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd8,  32'hDEAD_BEE1, 32'h1040_8003, 32'h8000_0020, 0);
      vecs[4]  = mk(0, 5'd0,  32'd0,         6'd0, 0,   5'd0,  1,   32'd0,         1'b0, 32'd0,         5'd12, 32'h1040_8001, 32'h1040_8001, 32'h8000_0020, 0);
      vecs[5]  = mk(1, 5'd12, 32'hFFFF_FFFF, 6'd0, 1,   5'd10, 0,   32'h8000_0300, 1'b0, 32'd0,         5'd14, 32'h8000_0300, 32'h1040_FF03, 32'h0000_0028, 0);
      vecs[6]  = mk(0, 5'd0,  32'd0,         6'd0, 0,   5'd0,  1,   32'd0,         1'b0, 32'd0,         5'd12, 32'h1040_FF01, 32'h1040_FF01, 32'h0000_0028, 0);
      vecs[7]  = mk(1, 5'd13, 32'hFFFF_FFFF, 6'd0, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd13, 32'h0000_0328, 32'h1040_FF01, 32'h0000_0328, -1);
      vecs[8]  = mk(0, 5'd0,  32'd0,         6'd0, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd13, 32'h0000_0328, 32'h1040_FF01, 32'h0000_0328, 1);
      vecs[9]  = mk(1, 5'd13, 32'd0,         6'd0, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd13, 32'h0000_0028, 32'h1040_FF01, 32'h0000_0028, -1);
      vecs[10] = mk(0, 5'd0,  32'd0,         6'd0, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd13, 32'h0000_0028, 32'h1040_FF01, 32'h0000_0028, 0);
      vecs[11] = mk(1, 5'd12, 32'h0000_1001, 6'd0, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd12, 32'h1040_1001, 32'h1040_1001, 32'h0000_0028, 0);
      vecs[12] = mk(0, 5'd0,  32'd0,         6'd4, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd13, 32'h0000_1028, 32'h1040_1001, 32'h0000_1028, -1);
      vecs[13] = mk(0, 5'd0,  32'd0,         6'd4, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd13, 32'h0000_1028, 32'h1040_1001, 32'h0000_1028, 1);
      vecs[14] = mk(1, 5'd15, 32'd0,         6'd4, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd15, 32'h0001_8000, 32'h1040_1001, 32'h0000_1028, 1);
      vecs[15] = mk(1, 5'd16, 32'd0,         6'd4, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd16, 32'h8000_0000, 32'h1040_1001, 32'h0000_1028, 1);
      vecs[16] = mk(0, 5'd0,  32'd0,         6'd4, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd3,  32'd0,         32'h1040_1001, 32'h0000_1028, 1);
      vecs[17] = mk(1, 5'd14, 32'h1357_9BDF, 6'd4, 0,   5'd0,  0,   32'd0,         1'b0, 32'd0,         5'd14, 32'h1357_9BDF, 32'h1040_1001, 32'h0000_1028, 1);

      for (int i = 0; i < 18; i++) begin
         apply(vecs[i]);
         check($sformatf("v%0d_data", i), data_o, vecs[i].exp_data);
         check($sformatf("v%0d_status", i), status_o, vecs[i].exp_status);
         check($sformatf("v%0d_cause", i), cause_o, vecs[i].exp_cause);
         if (vecs[i].exp_ireq >= 0)
            check($sformatf("v%0d_int_req", i), {31'd0, int_req_o}, 32'(vecs[i].exp_ireq));
      end
      check("epc_port", epc_o, 32'h1357_9BDF);

      // ---- Asynchronous reset mid-cycle with an interrupt pending ----
      v = rd(5'd9);
      v.intv = 6'd4;
      apply(v);
      check("ireq_before_rst", {31'd0, int_req_o}, 32'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_ireq", {31'd0, int_req_o}, 32'd0);
      check("async_rst_count", data_o, 32'd0);
      check("async_rst_status", status_o, 32'h1040_0000);
      check("async_rst_cause", cause_o, 32'd0);
      int_i = 6'd0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("count_first_edge", data_o, 32'd0);
      @(posedge clk); #1;
      check("count_second_edge", data_o, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
